// File: rtl/dial_driver.sv
// dial_driver
//   Walks a single hot bit around a 10-position one-hot dial ring. A move
//   steps the requested number of positions in the requested direction and
//   holds each position for DWELL cycles.
//
//   Direction encoding matches the direction detector on the same bus:
//   dir=1 is forward (index decrements), dir=0 is reverse (index increments).
//
// Parameters
//   DWELL    : cycles each position is held, 1..255
//   INIT_POS : dial index loaded at reset, 0..9
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   move request, sampled in IDLE only
//   dir      in   move direction, latched at accept
//   steps    in   positions to move, 0..127, latched at accept
//   abort    in   cancel move in progress (only with DIAL_DRIVER_ABORT_EN)
//   keypad   out  one-hot dial position
//   position out  binary index of the hot bit
//   busy     out  high while a move is in progress
//   done     out  one-cycle pulse when a move completes
//
// Build option
//   DIAL_DRIVER_ABORT_EN : when defined, abort in MOVE returns to IDLE at the
//   next edge without a done pulse. When undefined, abort is ignored.

module dial_driver #(
  parameter int DWELL    = 4,
  parameter int INIT_POS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dir,
  input  logic [6:0] steps,
  input  logic       abort,
  output logic [9:0] keypad,
  output logic [3:0] position,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, MOVE} state_t;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
  localparam logic [3:0] POS_INIT = 4'(INIT_POS);
  localparam logic [9:0] KP_INIT  = 10'(1) << INIT_POS;

  state_t     state_q;
  logic       dir_q;
  logic [6:0] remaining_q;
  logic [7:0] dwell_cnt_q;
  logic [9:0] keypad_q;
  logic [3:0] position_q;
  logic       busy_q;
  logic       done_q;

  logic [3:0] pos_d;
  logic       step_now;
  logic       abort_hit;

`ifdef DIAL_DRIVER_ABORT_EN
  assign abort_hit = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  // Next ring position, modulo 10 in the latched direction.
  always_comb begin
    pos_d = position_q;
    if (dir_q)
      pos_d = (position_q == 4'd0) ? 4'd9 : position_q - 4'd1;
    else
      pos_d = (position_q == 4'd9) ? 4'd0 : position_q + 4'd1;
  end

  assign step_now = (state_q == MOVE) && (dwell_cnt_q == DWELL_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      remaining_q <= '0;
      dwell_cnt_q <= '0;
      keypad_q    <= KP_INIT;
      position_q  <= POS_INIT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (steps != 7'd0) begin
              state_q     <= MOVE;
              busy_q      <= 1'b1;
              dir_q       <= dir;
              remaining_q <= steps;
              dwell_cnt_q <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        MOVE: begin
          if (step_now) begin
            keypad_q    <= 10'(1) << pos_d;
            position_q  <= pos_d;
            dwell_cnt_q <= '0;
            remaining_q <= remaining_q - 7'd1;
            if (remaining_q == 7'd1) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              // A coincident abort still takes the final step but hides done.
              done_q  <= ~abort_hit;
            end
          end else begin
            dwell_cnt_q <= dwell_cnt_q + 8'd1;
          end
          if (abort_hit) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign keypad   = keypad_q;
  assign position = position_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
